// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder sequencer: FSM state encoding and
// the counter-width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        SA_IDLE,
        SA_SHIFT,
        SA_DONE
    } sa_state_e;

    function automatic int sa_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_shreg.sv
// Load / shift-right register with zero fill. Only the LSB leaves the block,
// since that is the bit fed to the full adder each cycle.
module serial_adder_shreg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] d_i,
    output logic         lsb_o
);

    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load_i)
            q_d = d_i;
        else if (shift_i)
            q_d = {1'b0, q_q[W-1:1]};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    assign lsb_o = q_q[0];

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial adder sequencer: feeds an external combinational full adder
// LSB-first over WIDTH cycles and returns the sum and carry on a held handshake.
module serial_adder_seq
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             fa_a_o,
    output logic             fa_b_o,
    output logic             fa_cin_o,
    input  logic             fa_sum_i,
    input  logic             fa_cout_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             busy_o
);

    localparam int CNT_W = sa_cnt_w(WIDTH);

    sa_state_e        state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] res_sum_q, res_sum_d;
    logic             res_cout_q, res_cout_d;
    logic             load, shift;
    logic             a_lsb, b_lsb;

    serial_adder_shreg #(.W(WIDTH)) u_a_shreg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (load),
        .shift_i (shift),
        .d_i     (a_i),
        .lsb_o   (a_lsb)
    );

    serial_adder_shreg #(.W(WIDTH)) u_b_shreg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (load),
        .shift_i (shift),
        .d_i     (b_i),
        .lsb_o   (b_lsb)
    );

    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        bit_cnt_d  = bit_cnt_q;
        res_sum_d  = res_sum_q;
        res_cout_d = res_cout_q;
        load       = 1'b0;
        shift      = 1'b0;
        fa_a_o     = 1'b0;
        fa_b_o     = 1'b0;
        fa_cin_o   = 1'b0;
        case (state_q)
            SA_IDLE: begin
                if (in_valid_i) begin
                    load      = 1'b1;
                    sum_d     = '0;
                    carry_d   = cin_i;
                    bit_cnt_d = '0;
                    state_d   = SA_SHIFT;
                end
            end
            SA_SHIFT: begin
                shift     = 1'b1;
                fa_a_o    = a_lsb;
                fa_b_o    = b_lsb;
                fa_cin_o  = carry_q;
                sum_d     = {fa_sum_i, sum_q[WIDTH-1:1]};
                carry_d   = fa_cout_i;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                // Result registers only change here, so the last result
                // survives the next load of sum_q.
                if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                    res_sum_d  = sum_d;
                    res_cout_d = fa_cout_i;
                    state_d    = SA_DONE;
                end
            end
            SA_DONE: begin
                if (out_ready_i)
                    state_d = SA_IDLE;
            end
            default: state_d = SA_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= SA_IDLE;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            bit_cnt_q  <= '0;
            res_sum_q  <= '0;
            res_cout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            carry_q    <= carry_d;
            bit_cnt_q  <= bit_cnt_d;
            res_sum_q  <= res_sum_d;
            res_cout_q <= res_cout_d;
        end
    end

    assign in_ready_o  = (state_q == SA_IDLE);
    assign out_valid_o = (state_q == SA_DONE);
    assign busy_o      = (state_q != SA_IDLE);
    assign sum_o       = res_sum_q;
    assign cout_o      = res_cout_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Scoreboard bench for serial_adder_seq with a behavioural full adder on fa_*.
module tb_serial_adder_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in, b_in;
    logic         cin;
    logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int           cyc = 0;
    int           n_vec = 0;
    int           n_err = 0;
    int           last_acc = 0;
    logic [W:0]   exp_q[$];
    logic [W-1:0] fa_seq;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    serial_adder_seq #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a_in),
        .b_i         (b_in),
        .cin_i       (cin),
        .fa_a_o      (fa_a),
        .fa_b_o      (fa_b),
        .fa_cin_o    (fa_cin),
        .fa_sum_i    (fa_sum),
        .fa_cout_i   (fa_cout),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum),
        .cout_o      (cout),
        .busy_o      (busy)
    );

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int guard = 0;
        in_valid = 1'b1; a_in = a; b_in = b; cin = c;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        n_vec++;
        if (!in_ready) begin
            $display("FAIL issue: in_ready=%0b, required 1", in_ready);
            n_err++;
        end else begin
            exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
        end
        @(negedge clk);
        in_valid = 1'b0;
        last_acc = cyc;
    endtask

    // Waits for out_valid, checks latency and pops the scoreboard.
    task automatic collect(input string tag);
        int guard = 0;
        logic [W:0] exp;
        fa_seq = '0;
        while (!out_valid && guard < 4 * W) begin
            fa_seq = {fa_a, fa_seq[W-1:1]};
            @(negedge clk);
            guard++;
        end
        n_vec++;
        if (!out_valid) begin
            $display("FAIL %s timeout: out_valid=0, required 1", tag);
            n_err++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        n_vec++;
        if (cyc - last_acc != W) begin
            $display("FAIL %s latency: got %0d, required %0d", tag, cyc - last_acc, W);
            n_err++;
        end
        n_vec++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s scoreboard: unexpected result %h", tag, {cout, sum});
            n_err++;
        end else begin
            exp = exp_q.pop_front();
            if ({cout, sum} !== exp) begin
                $display("FAIL %s result: got %h, required %h", tag, {cout, sum}, exp);
                n_err++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; cin = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({in_ready, out_valid, busy, fa_a, fa_b, fa_cin, cout, sum} !== {1'b1, 6'b0, {W{1'b0}}}) begin
            $display("FAIL reset: got %b, required %b",
                     {in_ready, out_valid, busy, fa_a, fa_b, fa_cin, cout, sum}, {1'b1, 6'b0, {W{1'b0}}});
            n_err++;
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        issue(8'h5A, 8'h33, 1'b0);
        collect("basic");
        n_vec++;
        if (fa_seq !== 8'h5A) begin
            $display("FAIL basic fa_a sequence: got %h, required 5a", fa_seq);
            n_err++;
        end
        n_vec++;
        if ({cout, sum} !== 9'h08D) begin
            $display("FAIL basic sum: got %h, required 08d", {cout, sum});
            n_err++;
        end
        @(negedge clk);
    endtask

    task automatic test_carry();
        logic [W-1:0] ta[3] = '{8'hFF, 8'hFF, 8'h00};
        logic [W-1:0] tb[3] = '{8'h01, 8'hFF, 8'h00};
        logic         tc[3] = '{1'b0, 1'b1, 1'b0};
        logic [W:0]   te[3] = '{9'h100, 9'h1FF, 9'h000};
        for (int i = 0; i < 3; i++) begin
            issue(ta[i], tb[i], tc[i]);
            collect("carry");
            n_vec++;
            if ({cout, sum} !== te[i]) begin
                $display("FAIL carry[%0d]: got %h, required %h", i, {cout, sum}, te[i]);
                n_err++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        issue(8'h3C, 8'h0F, 1'b1);
        collect("backpressure");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if ({out_valid, in_ready, cout, sum} !== {2'b10, 9'h04C}) begin
                $display("FAIL backpressure hold[%0d]: got %h, required %h",
                         i, {out_valid, in_ready, cout, sum}, {2'b10, 9'h04C});
                n_err++;
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({in_ready, out_valid} !== 2'b10) begin
            $display("FAIL backpressure release: in_ready/out_valid=%b, required 10", {in_ready, out_valid});
            n_err++;
        end
    endtask

    task automatic test_ignore();
        issue(8'h10, 8'h20, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; a_in = 8'h01; b_in = 8'h01;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_vec++;
            if ({in_ready, busy} !== 2'b01) begin
                $display("FAIL ignore ready: in_ready/busy=%b, required 01", {in_ready, busy});
                n_err++;
            end
        end
        in_valid = 1'b0;
        collect("ignore");
        n_vec++;
        if ({cout, sum} !== 9'h030) begin
            $display("FAIL ignore sum: got %h, required 030", {cout, sum});
            n_err++;
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin
            $display("FAIL ignore extra op: busy=%0b, required 0", busy);
            n_err++;
        end
    endtask

    task automatic test_reset_mid();
        issue(8'hAA, 8'h55, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1; in_valid = 1'b1; a_in = 8'h07; b_in = 8'h07;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        n_vec++;
        if ({in_ready, out_valid, busy, fa_a, fa_b, fa_cin, cout, sum} !== {1'b1, 6'b0, {W{1'b0}}}) begin
            $display("FAIL reset_mid: got %b, required %b",
                     {in_ready, out_valid, busy, fa_a, fa_b, fa_cin, cout, sum}, {1'b1, 6'b0, {W{1'b0}}});
            n_err++;
        end
        void'(exp_q.pop_back());
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin
            $display("FAIL reset_mid accept during reset: busy=%0b, required 0", busy);
            n_err++;
        end
        issue(8'h80, 8'h80, 1'b0);
        collect("reset_mid");
        n_vec++;
        if ({cout, sum} !== 9'h100) begin
            $display("FAIL reset_mid sum: got %h, required 100", {cout, sum});
            n_err++;
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int prev = -1;
        int guard = 0;
        logic chg = 1'b0;
        logic [W:0] exp;
        out_ready = 1'b1;
        in_valid = 1'b1;
        a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom_range(0, 1));
        while ((acc < 200 || exp_q.size() > 0) && guard < 200 * (W + 2) + 100) begin
            if (out_valid) begin
                n_vec++;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                if ({cout, sum} !== exp) begin
                    $display("FAIL b2b result: got %h, required %h", {cout, sum}, exp);
                    n_err++;
                end
            end
            if (in_ready && in_valid) begin
                exp_q.push_back({1'b0, a_in} + {1'b0, b_in} + {{W{1'b0}}, cin});
                if (prev >= 0) begin
                    n_vec++;
                    if (cyc + 1 - prev != W + 2) begin
                        $display("FAIL b2b spacing: got %0d, required %0d", cyc + 1 - prev, W + 2);
                        n_err++;
                    end
                end
                prev = cyc + 1;
                acc++;
                chg = 1'b1;
            end else if (chg) begin
                a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom_range(0, 1));
                chg = 1'b0;
                if (acc >= 200) in_valid = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        n_vec++;
        if (acc < 200 || exp_q.size() > 0) begin
            $display("FAIL b2b timeout: accepted %0d, pending %0d, required 200 and 0", acc, exp_q.size());
            n_err++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
